// File: rtl/gauss_row_sequencer.sv
// Gaussian row sequencer: streams one pixel row through an 11-tap window with
// left/right edge replication and presents each window to an external dot product.
module gauss_row_sequencer #(
    parameter int MAX_W = 1024,
    parameter int CNT_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        cfg_sigma,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic [2:0]        dp_sigma,
    output logic [10:0][7:0]  dp_din,
    input  logic [7:0]        dp_dout,
    output logic              busy,
    output logic              done
);
    // One extra bit so N+4 shift positions never wrap for any legal N.
    localparam int SH_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sigma_q, sigma_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [10:0][7:0]  win_q, win_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  width_s;
    logic [SH_W-1:0]   sh_end_s;
    logic              shift_ok_s, s_ready_s, acc_s, load_s;
    logic              flush_sh_s, shift_s, emit_s, last_hs_s;
    logic [7:0]        new_px_s;

    // Handshake qualifiers and the shift/emit decision for this cycle
    always_comb begin
        shift_ok_s = ~m_valid_q | m_ready;
        sh_end_s   = {1'b0, n_q} + SH_W'(4);
        s_ready_s  = ((state_q == FILL) || (state_q == RUN)) && (in_cnt_q < n_q) && shift_ok_s;
        acc_s      = s_valid & s_ready_s;
        load_s     = acc_s && (in_cnt_q == {CNT_W{1'b0}});
        flush_sh_s = (state_q == FLUSH) && shift_ok_s && (sh_cnt_q < sh_end_s);
        shift_s    = (acc_s && !load_s) || flush_sh_s;
        // The fifth shift after p0 is the first that puts a real pixel 0 at the centre tap.
        emit_s     = shift_s && (sh_cnt_q >= SH_W'(4));
        last_hs_s  = m_valid_q && m_ready && m_last_q;
        new_px_s   = flush_sh_s ? win_q[10] : s_data;
        if (cfg_width == {CNT_W{1'b0}}) begin
            width_s = CNT_W'(1);
        end else if (cfg_width > CNT_W'(MAX_W)) begin
            width_s = CNT_W'(MAX_W);
        end else begin
            width_s = cfg_width;
        end
    end

    // Next-state, window and output-register logic
    always_comb begin
        state_d   = state_q;
        sigma_d   = sigma_q;
        n_d       = n_q;
        in_cnt_d  = in_cnt_q;
        sh_cnt_d  = sh_cnt_q;
        win_d     = win_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (load_s) begin
            win_d = {11{s_data}};
        end else if (shift_s) begin
            win_d = {new_px_s, win_q[10:1]};
        end else begin
            win_d = win_q;
        end

        if (acc_s) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end else begin
            in_cnt_d = in_cnt_q;
        end

        if (shift_s) begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
        end else begin
            sh_cnt_d = sh_cnt_q;
        end

        if (emit_s) begin
            m_valid_d = 1'b1;
            m_last_d  = (sh_cnt_q == (sh_end_s - SH_W'(1)));
        end else if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
            m_last_d  = m_last_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FILL;
                    sigma_d  = cfg_sigma;
                    n_d      = width_s;
                    in_cnt_d = {CNT_W{1'b0}};
                    sh_cnt_d = {SH_W{1'b0}};
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (acc_s && (in_cnt_d == n_q)) begin
                    state_d = FLUSH;
                end else if (shift_s && (sh_cnt_d == SH_W'(5))) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                if (acc_s && (in_cnt_d == n_q)) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (last_hs_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sigma_q   <= 3'd0;
            n_q       <= {CNT_W{1'b0}};
            in_cnt_q  <= {CNT_W{1'b0}};
            sh_cnt_q  <= {SH_W{1'b0}};
            win_q     <= {88{1'b0}};
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sigma_q   <= sigma_d;
            n_q       <= n_d;
            in_cnt_q  <= in_cnt_d;
            sh_cnt_q  <= sh_cnt_d;
            win_q     <= win_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready  = s_ready_s;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = dp_dout;
    assign dp_sigma = sigma_q;
    assign dp_din   = win_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gauss_row_sequencer.sv
// Scoreboard bench for gauss_row_sequencer: directed rows, expected outputs
// queued at stimulus time and checked by an independent output monitor.
module tb_gauss_row_sequencer;
    localparam int CNT_W = 11;

    logic              clk = 1'b0;
    logic              rst_n, start;
    logic [2:0]        cfg_sigma;
    logic [CNT_W-1:0]  cfg_width;
    logic              s_valid, s_ready;
    logic [7:0]        s_data;
    logic              m_valid, m_ready, m_last;
    logic [7:0]        m_data;
    logic [2:0]        dp_sigma;
    logic [10:0][7:0]  dp_din;
    logic [7:0]        dp_dout;
    logic              busy, done;

    gauss_row_sequencer #(.MAX_W(1024), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_sigma(cfg_sigma), .cfg_width(cfg_width),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .dp_sigma(dp_sigma), .dp_din(dp_din), .dp_dout(dp_dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic l; } exp_t;
    exp_t       sb[$];
    int         errors = 0, checks = 0, pops = 0, cyc = 0;
    int         mode = 1;
    bit         rdy_rand = 1'b0, acc_seen = 1'b1;
    int         first_acc = 0, done_cyc = 0;
    logic [7:0] pix [64];

    // Dot-product stub: 0 -> oldest tap, 1 -> centre, 2 -> newest, 3 -> weighted kernel
    function automatic logic [7:0] kern(input logic [2:0] sg, input logic [10:0][7:0] w);
        int acc = 0;
        for (int k = 0; k < 11; k++) acc += int'(w[k]) * (((k <= 5) ? k + 1 : 11 - k) + int'(sg));
        return 8'(acc >> 4);
    endfunction

    function automatic logic [7:0] dp_model(input int md, input logic [2:0] sg, input logic [10:0][7:0] w);
        case (md)
            0:       return w[0];
            2:       return w[10];
            3:       return kern(sg, w);
            default: return w[5];
        endcase
    endfunction

    always_comb dp_dout = dp_model(mode, dp_sigma, dp_din);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Expected row from the clamped-neighbourhood reference
    task automatic push_row(input int n, input logic [2:0] sg);
        logic [10:0][7:0] w;
        int idx;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 11; k++) begin
                idx = j - 5 + k;
                if (idx < 0) idx = 0;
                if (idx > n - 1) idx = n - 1;
                w[k] = pix[idx];
            end
            sb.push_back({dp_model(mode, sg, w), (j == n - 1)});
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: pops on every handshake, checks hold while stalled
    initial begin : monitor
        bit         held = 1'b0;
        logic [7:0] hd;
        logic       hl;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, hl, hd});
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(m_data), 32'hdead);
                    end else begin
                        e = sb.pop_front();
                        chk("m_data", 32'(m_data), 32'(e.d));
                        chk("m_last", 32'(m_last), 32'(e.l));
                        pops++;
                    end
                    held = 1'b0;
                end else if (m_valid) begin
                    held = 1'b1;
                    hd = m_data;
                    hl = m_last;
                end else begin
                    held = 1'b0;
                end
                if (s_valid && s_ready && !acc_seen) begin
                    acc_seen = 1'b1;
                    first_acc = cyc;
                end
                if (done) done_cyc = cyc;
            end
        end
    end

    task automatic run_row(input int cfgw, input int n, input logic [2:0] sg, input bit rv,
                           input int mid, input int abort_at);
        int base = pops;
        int g;
        push_row(n, sg);
        @(posedge clk); #1;
        cfg_sigma = sg; cfg_width = CNT_W'(cfgw); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        cfg_sigma = ~sg; cfg_width = CNT_W'(5);
        for (int i = 0; i < n; i++) begin
            if (abort_at > 0 && (pops - base) >= abort_at) return;
            if (rv && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (i == mid) start = 1'b1;
            s_valid = 1'b1; s_data = pix[i];
            g = 0;
            do begin @(negedge clk); g++; end while (!s_ready && g < 500);
            if (g >= 500) chk("accept_timeout", 32'(g), 32'd0);
            @(posedge clk); #1;
            s_valid = 1'b0; start = 1'b0;
        end
        if (abort_at > 0) return;
        s_valid = 1'b1; s_data = 8'hee;
        @(negedge clk);
        chk("s_ready_after_N", 32'(s_ready), 32'd0);
        #1 s_valid = 1'b0;
        g = 0;
        while (!done && g < 3000) begin @(negedge clk); g++; end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_pulse", {busy, done}, 32'd0);
        chk("row_count", sb.size(), 32'd0);
    endtask

    initial begin
        int g, bad;
        rst_n = 1'b0; start = 1'b0; cfg_sigma = 3'd0; cfg_width = '0;
        s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {m_valid, m_last, s_ready, busy, done}, 32'd0);
        chk("rst_dp", {dp_sigma, 1'b0, (dp_din == '0)}, 32'd1);
        rst_n = 1'b1;

        // Ramp row, centre tap, with end-to-end latency
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        mode = 1; acc_seen = 1'b0;
        run_row(16, 16, 3'd2, 1'b0, -1, 0);
        chk("row_time", done_cyc - first_acc, 32'd22);

        // Edge replication seen through the outer taps
        mode = 0; run_row(16, 16, 3'd1, 1'b0, -1, 0);
        mode = 2; run_row(16, 16, 3'd1, 1'b0, -1, 0);

        // Short row: fill goes straight to flush
        pix[0] = 8'h0c; pix[1] = 8'hc6; pix[2] = 8'h1e;
        mode = 2; run_row(3, 3, 3'd0, 1'b0, -1, 0);

        // Weighted kernel, every sigma, random back-pressure and input gaps
        pix[0] = 8'd12;  pix[1] = 8'd198; pix[2] = 8'd30;  pix[3] = 8'd142;
        pix[4] = 8'd172; pix[5] = 8'd225; pix[6] = 8'd227; pix[7] = 8'd220;
        pix[8] = 8'd246; pix[9] = 8'd129; pix[10] = 8'd134;
        mode = 3; rdy_rand = 1'b1;
        for (int s = 0; s < 8; s++) run_row(11, 11, 3'(s), 1'b1, -1, 0);
        rdy_rand = 1'b0;

        // Zero width behaves as one pixel
        mode = 1; pix[0] = 8'h5a;
        run_row(0, 1, 3'd3, 1'b0, -1, 0);

        // Start pulse during RUN is ignored
        for (int i = 0; i < 12; i++) pix[i] = 8'(8'h40 + i * 3);
        run_row(12, 12, 3'd4, 1'b0, 8, 0);

        // Reset mid-row
        for (int i = 0; i < 16; i++) pix[i] = 8'(8'h80 + i);
        g = pops;
        run_row(16, 16, 3'd5, 1'b0, -1, 7);
        bad = 0;
        while ((pops - g) < 7 && bad < 200) begin @(negedge clk); bad++; end
        chk("outputs_before_reset", pops - g, 32'd7);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrow_rst_outs", {m_valid, m_last, s_ready, busy, done, m_data}, 32'd0);
        chk("midrow_rst_dp", {dp_sigma, 1'b0, (dp_din == '0)}, 32'd1);
        sb.delete();
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) bad++;
        end
        chk("no_valid_after_reset", bad, 32'd0);
        pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
        run_row(4, 4, 3'd6, 1'b0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
